debounce_multi: RTL

- Parametrised N-channel successor to the single-bit switch debouncer on the board top level.
- Synchronises asynchronous board inputs (slide switches, buttons) into the `clk` domain, then filters each channel independently with a stability counter.
- Emits debounced levels, one-cycle rise/fall pulses and an aggregate change event with a wrapping event counter.
- Sits between board pins and the Qsys PIO/export ports; one instance replaces the per-bit generate loop.

---
 rtl/debounce_pkg.sv | 10 +
 rtl/debounce_channel.sv | 55 +++++
 rtl/debounce_multi.sv | 68 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter sizing helper for the multi-channel debouncer.
package debounce_pkg;
   localparam int DEF_STABLE_CYCLES = 1000000;
   localparam int DEF_SYNC_STAGES   = 2;
   function automatic int min_cnt_w(input int stable);
      int w = 1;
      while ((longint'(1) << w) <= longint'(stable)) w++;
      return w;
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one input bit through a sync chain and a stability filter,
// with registered one-cycle rise/fall pulses on acceptance.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int   CNT_W         = 20,
   parameter logic RESET_BIT     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   input  logic hold,
   output logic result,
   output logic rise,
   output logic fall,
   output logic accept
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic result_q, result_d, rise_q, rise_d, fall_q, fall_d;
   logic s, match, done;
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], din};
      s        = sync_q[SYNC_STAGES-1];
      match    = !hold && (s != result_q);
      done     = match && (cnt_q == LAST);
      // hold freezes the count; any agreement with the output restarts it
      cnt_d    = hold ? cnt_q : (match && !done) ? cnt_q + CNT_W'(1) : '0;
      result_d = done ? s : result_q;
      rise_d   = done && s;
      fall_d   = done && !s;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= {SYNC_STAGES{RESET_BIT}};
         cnt_q    <= '0;
         result_q <= RESET_BIT;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end
   assign result = result_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign accept = done;
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N independent debounced channels plus an aggregate change
// pulse and a wrapping count of change events.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int              N_CH          = 4,
   parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int              CNT_W         = 20,
   parameter logic [N_CH-1:0] RESET_VAL     = '0,
   parameter int              EVT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  din,
   input  logic             hold,
   output logic [N_CH-1:0]  result,
   output logic [N_CH-1:0]  rise,
   output logic [N_CH-1:0]  fall,
   output logic             changed,
   output logic [EVT_W-1:0] evt_count
);
   if (CNT_W < min_cnt_w(STABLE_CYCLES)) begin : g_bad_cnt_w
      $error("CNT_W too small for STABLE_CYCLES");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be 2..4");
   end
   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("STABLE_CYCLES must be >= 2");
   end
   logic [N_CH-1:0] accept;
   logic changed_q, changed_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES),
         .CNT_W        (CNT_W),
         .RESET_BIT    (RESET_VAL[i])
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .din   (din[i]),
         .hold  (hold),
         .result(result[i]),
         .rise  (rise[i]),
         .fall  (fall[i]),
         .accept(accept[i])
      );
   end
   // several channels accepting together still count as one event
   always_comb begin
      changed_d = |accept;
      evt_d     = evt_q + EVT_W'(changed_d);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         changed_q <= 1'b0;
         evt_q     <= '0;
      end else begin
         changed_q <= changed_d;
         evt_q     <= evt_d;
      end
   end
   assign changed   = changed_q;
   assign evt_count = evt_q;
endmodule
